// File: rtl/pcileech_ft601_pkg.sv
// Shared types and constants for the FT601 TX arbiter.
// Holds the arbiter state encoding, the tag magic and a clog2 helper.
package pcileech_ft601_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TAG  = 2'd1,
      XFER = 2'd2,
      GAP  = 2'd3
   } tx_arb_state_t;

   localparam logic [15:0] TX_TAG_MAGIC = 16'hE0E0;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pcileech_ft601_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr_i,
// wrapping at N.
module pcileech_rr_pick #(
   parameter int N = 3
) (
   input  logic [N-1:0] valid_i,
   input  logic [2:0]   ptr_i,
   output logic         found_o,
   output logic [2:0]   idx_o
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [3:0]     sum;

   assign dbl = {valid_i, valid_i};
   assign rot = N'(dbl >> ptr_i);

   // Scan from the far end so the nearest valid entry wins.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      sum     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sum = {1'b0, ptr_i} + 4'(k);
            if (sum >= 4'(N)) sum = sum - 4'(N);
            found_o = 1'b1;
            idx_o   = sum[2:0];
         end
      end
   end

endmodule

// File: rtl/pcileech_ft601_tx_arbiter.sv
// Burst-granular round-robin arbiter feeding the FT601 TX word port.
// Define PCILEECH_FT_TX_TAG_EN to prefix every grant with a source tag word.
module pcileech_ft601_tx_arbiter
   import pcileech_ft601_pkg::*;
#(
   parameter int NUM_SRC   = 3,
   parameter int MAX_BURST = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [32*NUM_SRC-1:0] src_data,
   input  logic [NUM_SRC-1:0]    src_valid,
   input  logic [NUM_SRC-1:0]    src_last,
   output logic [NUM_SRC-1:0]    src_ready,
   input  logic                  ft_req_data,
   output logic [31:0]           ft_dout,
   output logic                  ft_dout_wr,
   output logic [2:0]            grant_id,
   output logic                  busy
);

   localparam int CW = (clog2(MAX_BURST) < 1) ? 1 : clog2(MAX_BURST);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);
   localparam logic [2:0]    LAST_ID = 3'(NUM_SRC - 1);

   tx_arb_state_t state_q;
   logic [2:0]    grant_q;
   logic [2:0]    rr_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q;
   logic          wr_q;
   logic [31:0]   dout_q;

   logic          pick_found;
   logic [2:0]    pick_idx;
   logic [7:0]    valid8;
   logic [7:0]    last8;
   logic [255:0]  data_pad;
   logic [31:0]   cur_data;
   logic          cur_valid;
   logic          cur_last;
   logic          xfer;
   logic          burst_end;

   pcileech_rr_pick #(.N(NUM_SRC)) u_pick (
      .valid_i (src_valid),
      .ptr_i   (rr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   assign valid8    = 8'(src_valid);
   assign last8     = 8'(src_last);
   assign data_pad  = 256'(src_data);
   assign cur_valid = valid8[grant_q];
   assign cur_last  = last8[grant_q];
   assign cur_data  = data_pad[{grant_q, 5'b0} +: 32];

   // A word held during reset is left with its source, never half-taken.
   assign xfer      = (state_q == XFER) && ft_req_data && cur_valid && !rst;
   assign burst_end = cur_last || (cnt_q == CNT_MAX);
   assign src_ready = NUM_SRC'(xfer ? (8'd1 << grant_q) : 8'd0);

   assign ft_dout    = dout_q;
   assign ft_dout_wr = wr_q;
   assign grant_id   = grant_q;
   assign busy       = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         wr_q    <= 1'b0;
         dout_q  <= '0;
      end else begin
         wr_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pick_found) begin
                  grant_q <= pick_idx;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
`ifdef PCILEECH_FT_TX_TAG_EN
                  state_q <= TAG;
`else
                  state_q <= XFER;
`endif
               end
            end
            TAG: begin
               if (ft_req_data) begin
                  wr_q    <= 1'b1;
                  dout_q  <= {TX_TAG_MAGIC, 13'h0, grant_q};
                  state_q <= XFER;
               end
            end
            XFER: begin
               if (xfer) begin
                  wr_q   <= 1'b1;
                  dout_q <= cur_data;
                  if (burst_end) begin
                     state_q <= GAP;
                     busy_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            GAP: begin
               rr_q    <= (grant_q == LAST_ID) ? 3'd0 : grant_q + 3'd1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pcileech_ft601_tx_arbiter.sv
// Randomized bench for pcileech_ft601_tx_arbiter against a queue-based
// model of packets, round-robin grants and burst limits.
module tb_pcileech_ft601_tx_arbiter;

   localparam int N  = 3;
   localparam int MB = 4;

   logic            clk;
   logic            rst;
   logic [32*N-1:0] src_data;
   logic [N-1:0]    src_valid;
   logic [N-1:0]    src_last;
   logic [N-1:0]    src_ready;
   logic            ft_req_data;
   logic [31:0]     ft_dout;
   logic            ft_dout_wr;
   logic [2:0]      grant_id;
   logic            busy;

   pcileech_ft601_tx_arbiter #(.NUM_SRC(N), .MAX_BURST(MB)) dut (
      .clk         (clk),
      .rst         (rst),
      .src_data    (src_data),
      .src_valid   (src_valid),
      .src_last    (src_last),
      .src_ready   (src_ready),
      .ft_req_data (ft_req_data),
      .ft_dout     (ft_dout),
      .ft_dout_wr  (ft_dout_wr),
      .grant_id    (grant_id),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-source pending words: {last, data}.
   logic [32:0] sq [N][$];

   int vecs = 0;
   int errs = 0;
   int cur = -1;
   int cnt = 0;
   int ptr = 0;
   int cyc = 0;
   int last_end = -100;
   int gap_pct = 0;
   int req_mode = 0;

   function automatic int pick(input int p);
      for (int k = 0; k < N; k++) begin
         if (sq[(p + k) % N].size() > 0) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic int pending();
      int s;
      s = 0;
      for (int i = 0; i < N; i++) s += sq[i].size();
      return s;
   endfunction

   task automatic load(input int s, input int n, input int lmode);
      bit l;
      for (int k = 0; k < n; k++) begin
         case (lmode)
            0: l = (k == n - 1);
            1: l = 1'b0;
            2: l = (k == n - 1) || ($urandom_range(2) == 0);
            default: l = (k % 2 == 1) || (k == n - 1);
         endcase
         sq[s].push_back({l, 32'($urandom)});
      end
   endtask

   task automatic step();
      logic [N-1:0] v;
      logic [N-1:0] rdy;
      logic [31:0]  w;
      bit           lst;
      int           hs;
      int           e;
      cyc++;
      v   = '0;
      w   = '0;
      lst = 1'b0;
      hs  = -1;
      for (int i = 0; i < N; i++) begin
         v[i] = (sq[i].size() > 0);
         if (i == cur && gap_pct > 0 && int'($urandom_range(99)) < gap_pct)
            v[i] = 1'b0;
         src_data[32*i +: 32] = (sq[i].size() > 0) ? sq[i][0][31:0] : $urandom;
         src_last[i] = (sq[i].size() > 0) ? sq[i][0][32] : 1'b0;
      end
      case (req_mode)
         0: ft_req_data = 1'b1;
         1: ft_req_data = ~ft_req_data;
         default: ft_req_data = ($urandom_range(3) != 0);
      endcase
      src_valid = v;
      #2;
      rdy = src_ready;
      vecs++;
      if (((rdy & ~(v & {N{ft_req_data}})) != '0) || !$onehot0(rdy)) begin
         errs++;
         $display("FAIL ready_legal: ready %b valid %b req %b", rdy, v, ft_req_data);
      end
      for (int i = 0; i < N; i++) if (rdy[i]) hs = i;
      if (hs >= 0) begin
         if (cur < 0) begin
`ifdef PCILEECH_FT_TX_TAG_EN
            vecs++;
            errs++;
            $display("FAIL tag_missing: data from src %0d with no tag word", hs);
`else
            e = pick(ptr);
            vecs++;
            if (hs != e || cyc - last_end < 3) begin
               errs++;
               $display("FAIL grant_order: got src %0d after %0d cycles, want src %0d after >=3",
                        hs, cyc - last_end, e);
            end
`endif
            cur = hs;
            cnt = 0;
         end else begin
            vecs++;
            if (hs != cur) begin
               errs++;
               $display("FAIL grant_hold: got src %0d want src %0d", hs, cur);
            end
         end
         vecs++;
         if (busy !== 1'b1 || grant_id !== 3'(hs)) begin
            errs++;
            $display("FAIL busy_grant: busy %b grant %0d want 1 / %0d", busy, grant_id, hs);
         end
         w   = sq[hs][0][31:0];
         lst = sq[hs][0][32];
         void'(sq[hs].pop_front());
         cnt++;
         if (lst || cnt == MB) begin
            ptr = (hs + 1) % N;
            cur = -1;
            last_end = cyc;
         end
      end
      @(posedge clk);
      #1;
      vecs++;
      if (hs >= 0) begin
         if (ft_dout_wr !== 1'b1 || ft_dout !== w) begin
            errs++;
            $display("FAIL data_word: wr %b dout %h want 1 / %h", ft_dout_wr, ft_dout, w);
         end
      end else if (ft_dout_wr !== 1'b0) begin
`ifdef PCILEECH_FT_TX_TAG_EN
         e = pick(ptr);
         if (cur >= 0 || cyc - last_end < 3 || ft_dout !== {16'hE0E0, 13'h0, 3'(e)}) begin
            errs++;
            $display("FAIL tag_word: dout %h cur %0d want %h", ft_dout, cur,
                     {16'hE0E0, 13'h0, 3'(e)});
         end
         cur = e;
         cnt = 0;
`else
         errs++;
         $display("FAIL spurious_write: wr %b dout %h want wr 0", ft_dout_wr, ft_dout);
`endif
      end
   endtask

   task automatic drain(output int n);
      n = 0;
      while ((pending() > 0 || cur >= 0) && n < 4000) begin
         step();
         n++;
      end
      vecs++;
      if (n >= 4000) begin
         errs++;
         $display("FAIL timeout: %0d words still pending after %0d cycles", pending(), n);
      end
      repeat (3) step();
      vecs++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL idle_busy: busy %b want 0", busy);
      end
   endtask

   task automatic apply_rst(input int ncyc);
      rst         = 1'b1;
      ft_req_data = 1'b0;
      src_valid   = '0;
      src_last    = '0;
      repeat (ncyc) @(posedge clk);
      #1;
      cyc += ncyc;
   endtask

   task automatic model_reset();
      rst      = 1'b0;
      cur      = -1;
      cnt      = 0;
      ptr      = 0;
      last_end = -100;
   endtask

   task automatic test_reset();
      apply_rst(2);
      vecs += 4;
      if (ft_dout_wr !== 1'b0) begin
         errs++; $display("FAIL rst_wr: got %b want 0", ft_dout_wr);
      end
      if (ft_dout !== 32'h0) begin
         errs++; $display("FAIL rst_dout: got %h want 0", ft_dout);
      end
      if (busy !== 1'b0) begin
         errs++; $display("FAIL rst_busy: got %b want 0", busy);
      end
      if (grant_id !== 3'd0) begin
         errs++; $display("FAIL rst_grant: got %0d want 0", grant_id);
      end
      model_reset();
   endtask

   task automatic test_single_burst();
      int n;
      req_mode = 0;
      gap_pct  = 0;
      load(0, 4, 0);
      drain(n);
      vecs++;
`ifdef PCILEECH_FT_TX_TAG_EN
      if (n != 6) begin
`else
      if (n != 5) begin
`endif
         errs++;
         $display("FAIL single_latency: burst took %0d cycles", n);
      end
   endtask

   task automatic test_simultaneous();
      int n;
      apply_rst(1);
      model_reset();
      load(0, 3, 0);
      load(2, 2, 0);
      drain(n);
      load(1, 1, 0);
      load(0, 1, 0);
      drain(n);
   endtask

   task automatic test_max_burst();
      int n;
      load(1, 12, 1);
      load(0, 6, 3);
      drain(n);
   endtask

   task automatic test_req_toggle();
      int n;
      req_mode = 1;
      load(2, 6, 2);
      load(1, 4, 2);
      drain(n);
      req_mode = 0;
   endtask

   task automatic test_rst_midburst();
      int n;
      load(1, 5, 0);
      n = 0;
      while (sq[1].size() > 3 && n < 50) begin
         step();
         n++;
      end
      vecs++;
      if (sq[1].size() != 3) begin
         errs++;
         $display("FAIL midburst_setup: %0d words left want 3", sq[1].size());
      end
      apply_rst(1);
      vecs += 3;
      if (ft_dout_wr !== 1'b0) begin
         errs++; $display("FAIL midrst_wr: got %b want 0", ft_dout_wr);
      end
      if (busy !== 1'b0) begin
         errs++; $display("FAIL midrst_busy: got %b want 0", busy);
      end
      if (grant_id !== 3'd0) begin
         errs++; $display("FAIL midrst_grant: got %0d want 0", grant_id);
      end
      model_reset();
      load(0, 2, 0);
      drain(n);
   endtask

   task automatic test_tag();
      int n;
      load(2, 1, 0);
      drain(n);
   endtask

   task automatic test_random();
      int n;
      for (int r = 0; r < 4; r++) begin
         gap_pct  = 30;
         req_mode = 2;
         for (int s = 0; s < N; s++) load(s, int'($urandom_range(9)), 2);
         drain(n);
      end
      gap_pct  = 0;
      req_mode = 0;
   endtask

   initial begin
      rst         = 1'b1;
      src_data    = '0;
      src_valid   = '0;
      src_last    = '0;
      ft_req_data = 1'b0;
      test_reset();
      test_single_burst();
      test_simultaneous();
      test_max_burst();
      test_req_toggle();
      test_rst_midburst();
      test_tag();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
